// File: rtl/uart_calc_core.sv
// Byte-stream calculator: collects two little-endian operands and a command, runs the ALU,
// then converts |result| to packed BCD with an iterative double-dabble.
module uart_calc_core #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned BCD_DIGITS = 5,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic [WIDTH-1:0]        op1,
  output logic [WIDTH-1:0]        op2,
  output logic [1:0]              alu_ctrl,
  output logic [WIDTH-1:0]        result,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    negative,
  output logic                    carry,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    error,
  output logic [2:0]              stage
);

  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned TmoW     = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW     = $clog2(WIDTH + 1);
  localparam int unsigned BcdW     = 4 * BCD_DIGITS;

  typedef enum logic [2:0] {
    StWaitOp1 = 3'd0,
    StWaitOp2 = 3'd1,
    StWaitCmd = 3'd2,
    StExec    = 3'd3,
    StConv    = 3'd4
  } state_e;

  state_e            state;
  logic [1:0]        byte_cnt;
  logic [TmoW-1:0]   tmo_cnt;
  logic [CntW-1:0]   conv_cnt;
  logic [WIDTH-1:0]  bin_sh;
  logic [BcdW-1:0]   bcd_sh;
  logic [BcdW-1:0]   bcd_adj;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH-1:0]  mag;
  logic              borrow;
  logic              last_byte;
  logic [4:0]        byte_lsb;

  assign stage     = state;
  assign busy      = (state == StExec) || (state == StConv);
  assign last_byte = (byte_cnt == 2'(NumBytes - 1));
  assign byte_lsb  = {byte_cnt, 3'b000};

  always_comb begin
    sum    = {1'b0, op1} + {1'b0, op2};
    borrow = op1 < op2;
    unique case (alu_ctrl)
      2'b00:   alu_res = sum[WIDTH-1:0];
      2'b01:   alu_res = op1 - op2;
      2'b10:   alu_res = op1 & op2;
      default: alu_res = op1 | op2;
    endcase
    mag = (alu_ctrl == 2'b01 && borrow) ? (op2 - op1) : alu_res;
  end

  // Add-3 correction on every digit >= 5 before each shift.
  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StWaitOp1;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      conv_cnt     <= '0;
      bin_sh       <= '0;
      bcd_sh       <= '0;
      op1          <= '0;
      op2          <= '0;
      alu_ctrl     <= '0;
      result       <= '0;
      bcd          <= '0;
      negative     <= 1'b0;
      carry        <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      error <= 1'b0;
      unique case (state)
        StWaitOp1, StWaitOp2, StWaitCmd: begin
          if (rx_ready) begin
            tmo_cnt <= '0;
            if (state == StWaitCmd) begin
              if (rx_data[7:2] == 6'd0) begin
                alu_ctrl <= rx_data[1:0];
                state    <= StExec;
              end else begin
                error <= 1'b1;
                state <= StWaitOp1;
              end
            end else begin
              if (state == StWaitOp1) begin
                if (byte_cnt == 2'd0) begin
                  // Starting a new transaction wipes the previous display.
                  op1          <= WIDTH'(rx_data);
                  op2          <= WIDTH'(op2[7:0]);
                  result       <= '0;
                  bcd          <= '0;
                  negative     <= 1'b0;
                  carry        <= 1'b0;
                  result_valid <= 1'b0;
                end else begin
                  op1[byte_lsb +: 8] <= rx_data;
                end
              end else begin
                op2[byte_lsb +: 8] <= rx_data;
              end
              if (last_byte) begin
                byte_cnt <= '0;
                state    <= (state == StWaitOp1) ? StWaitOp2 : StWaitCmd;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
          end else if (state != StWaitOp1 || byte_cnt != 2'd0) begin
            if (tmo_cnt == TmoW'(TIMEOUT - 1)) begin
              error    <= 1'b1;
              state    <= StWaitOp1;
              byte_cnt <= '0;
              tmo_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end else begin
            tmo_cnt <= '0;
          end
        end
        StExec: begin
          if (rx_ready) error <= 1'b1;
          result   <= alu_res;
          carry    <= (alu_ctrl == 2'b00) ? sum[WIDTH] : (alu_ctrl == 2'b01) ? borrow : 1'b0;
          negative <= (alu_ctrl == 2'b01) && borrow;
          bin_sh   <= mag;
          bcd_sh   <= '0;
          conv_cnt <= '0;
          state    <= StConv;
        end
        StConv: begin
          if (rx_ready) error <= 1'b1;
          if (conv_cnt == CntW'(WIDTH)) begin
            bcd          <= bcd_sh;
            result_valid <= 1'b1;
            state        <= StWaitOp1;
          end else begin
            bcd_sh   <= {bcd_adj[BcdW-2:0], bin_sh[WIDTH-1]};
            bin_sh   <= {bin_sh[WIDTH-2:0], 1'b0};
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        default: state <= StWaitOp1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_calc_core.sv
// Directed bench for uart_calc_core with hand-computed expected values.
module tb_uart_calc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] op1, op2, result;
  logic [1:0]  alu_ctrl;
  logic [19:0] bcd;
  logic        negative, carry, result_valid, busy, error;
  logic [2:0]  stage;

  int checks = 0;
  int errors = 0;

  uart_calc_core #(.WIDTH(16), .BCD_DIGITS(5), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .op1(op1), .op2(op2), .alu_ctrl(alu_ctrl), .result(result), .bcd(bcd),
    .negative(negative), .carry(carry), .result_valid(result_valid), .busy(busy),
    .error(error), .stage(stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  // Edges after the last send until result_valid is seen (60 means never).
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (result_valid) break;
    end
  endtask

  int n, err_cnt, err_at;

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    #1;
    chk("rst_op1", op1, 0);
    chk("rst_result", result, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_stage", stage, 0);
    chk("rst_busy_err", {busy, error}, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: add 0x1234 + 0x0001
    send(8'h34); send(8'h12);
    chk("t1_stage_op2", stage, 1);
    send(8'h01); send(8'h00);
    chk("t1_stage_cmd", stage, 2);
    send(8'h00);
    chk("t1_exec", {busy, stage}, {1'b1, 3'd3});
    wait_valid(n);
    chk("t1_latency", n, 18);
    chk("t1_ops", {op1, op2}, 32'h1234_0001);
    chk("t1_result", result, 16'h1235);
    chk("t1_bcd", bcd, 20'h04661);
    chk("t1_flags", {carry, negative, busy, stage}, 0);

    // 2: sub 5 - 7
    send(8'h05); send(8'h00); send(8'h07); send(8'h00); send(8'h01);
    wait_valid(n);
    chk("t2_latency", n, 18);
    chk("t2_result", result, 16'hFFFE);
    chk("t2_neg_carry", {negative, carry}, 2'b11);
    chk("t2_bcd", bcd, 20'h00002);

    // 3: add wrap-around cases
    send(8'hFF); send(8'hFF); send(8'h01); send(8'h00); send(8'h00);
    wait_valid(n);
    chk("t3a_result", result, 16'h0000);
    chk("t3a_carry_neg", {carry, negative}, 2'b10);
    chk("t3a_bcd_valid", {result_valid, bcd}, {1'b1, 20'h00000});
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF); send(8'h00);
    wait_valid(n);
    chk("t3b_result", result, 16'hFFFE);
    chk("t3b_carry", carry, 1);
    chk("t3b_bcd", bcd, 20'h65534);

    // 4: timeout after a partial operand, then an OR
    send(8'h34);
    chk("t4_cleared", {result_valid, result}, 0);
    err_cnt = 0;
    err_at  = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk);
      #1;
      if (error) begin
        err_cnt++;
        if (err_at == 0) err_at = i;
      end
    end
    chk("t4_err_pulses", err_cnt, 1);
    chk("t4_err_edge", err_at, 1000);
    chk("t4_stage", stage, 0);
    send(8'h0A); send(8'h00); send(8'h03); send(8'h00); send(8'h03);
    wait_valid(n);
    chk("t4_result", result, 16'h000B);
    chk("t4_bcd", bcd, 20'h00011);
    chk("t4_carry", carry, 0);

    // 5: bad command, then a byte during conversion
    send(8'h01); send(8'h00); send(8'h02); send(8'h00);
    send(8'h07);
    chk("t5_badcmd", {error, stage, result_valid}, {1'b1, 3'd0, 1'b0});
    chk("t5_ctrl_kept", alu_ctrl, 2'b11);
    @(posedge clk);
    #1;
    chk("t5_err_oneshot", error, 0);
    send(8'h09); send(8'h00); send(8'h04); send(8'h00); send(8'h00);
    repeat (4) @(posedge clk);
    send(8'h55);
    chk("t5_busy_drop", {error, stage}, {1'b1, 3'd4});
    wait_valid(n);
    chk("t5_result", result, 16'h000D);
    chk("t5_bcd", {result_valid, bcd}, {1'b1, 20'h00013});
    chk("t5_op2", op2, 16'h0004);

    // 6: async reset during conversion
    send(8'h02); send(8'h00); send(8'h03); send(8'h00); send(8'h00);
    repeat (5) @(posedge clk);
    #2;
    chk("t6_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_outputs", {op1, op2, result, bcd}, 0);
    chk("t6_ctrl", {alu_ctrl, negative, carry, result_valid, busy, error, stage}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_valid", {result_valid, stage}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
